// File: rtl/nios_system_sysinfo_pkg.sv
// rtl/nios_system_sysinfo_pkg.sv - register map and CTRL bit positions for the sysinfo slave
package nios_system_sysinfo_pkg;
  localparam logic [2:0] REG_ID        = 3'd0;
  localparam logic [2:0] REG_TIMESTAMP = 3'd1;
  localparam logic [2:0] REG_SCRATCH   = 3'd2;
  localparam logic [2:0] REG_UPTIME_LO = 3'd3;
  localparam logic [2:0] REG_UPTIME_HI = 3'd4;
  localparam logic [2:0] REG_CTRL      = 3'd5;
  localparam logic [2:0] REG_INFO      = 3'd6;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_WRAP = 2;

  localparam logic [7:0] MAP_VERSION = 8'd1;
endpackage

// File: rtl/nios_system_sysinfo_uptime.sv
// rtl/nios_system_sysinfo_uptime.sv - free-running uptime counter with enable, clear and sticky wrap
module nios_system_sysinfo_uptime #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ctrl_wr,
  input  logic         i_en_wdata,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_en,
  output logic         o_wrap
);
  logic [W-1:0] r_count;
  logic         r_en;
  logic         r_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_en    <= 1'b1;
      r_wrap  <= 1'b0;
    end else begin
      if (i_ctrl_wr) begin
        r_en <= i_en_wdata;
      end
      // Clear takes priority over an increment or wrap landing on the same edge.
      if (i_ctrl_wr && i_clr) begin
        r_count <= '0;
        r_wrap  <= 1'b0;
      end else if (r_en) begin
        r_count <= r_count + W'(1);
        if (&r_count) begin
          r_wrap <= 1'b1;
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_en    = r_en;
  assign o_wrap  = r_wrap;
endmodule

// File: rtl/nios_system_sysinfo.sv
// rtl/nios_system_sysinfo.sv - Avalon-MM system-info slave: ID, timestamp, scratch, uptime snapshot
module nios_system_sysinfo
  import nios_system_sysinfo_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter logic [31:0]       ID_VALUE    = 32'd0,
  parameter logic [31:0]       TIMESTAMP   = 32'd1674984379,
  parameter logic [DATA_W-1:0] SCRATCH_RST = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);
  localparam logic [DATA_W-1:0] LP_ID   = ID_VALUE[DATA_W-1:0];
  localparam logic [DATA_W-1:0] LP_TS   = TIMESTAMP[DATA_W-1:0];
  localparam logic [7:0]        LP_W8   = 8'(DATA_W);

  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_scratch;
  logic [DATA_W-1:0]   r_shadow_hi;

  logic                w_rd;
  logic                w_ctrl_wr;
  logic [2*DATA_W-1:0] w_count;
  logic                w_en;
  logic                w_wrap;
  logic [DATA_W-1:0]   w_rdata;

  // A simultaneous write suppresses the read response entirely.
  assign w_rd      = read && !write;
  assign w_ctrl_wr = write && (address == REG_CTRL);

  nios_system_sysinfo_uptime #(.W(2*DATA_W)) u_uptime (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_ctrl_wr  (w_ctrl_wr),
    .i_en_wdata (writedata[CTRL_EN]),
    .i_clr      (writedata[CTRL_CLR]),
    .o_count    (w_count),
    .o_en       (w_en),
    .o_wrap     (w_wrap)
  );

  always_comb begin
    w_rdata = '0;
    case (address)
      REG_ID:        w_rdata = LP_ID;
      REG_TIMESTAMP: w_rdata = LP_TS;
      REG_SCRATCH:   w_rdata = r_scratch;
      REG_UPTIME_LO: w_rdata = w_count[DATA_W-1:0];
      REG_UPTIME_HI: w_rdata = r_shadow_hi;
      REG_CTRL: begin
        w_rdata[CTRL_EN]   = w_en;
        w_rdata[CTRL_WRAP] = w_wrap;
      end
      REG_INFO: begin
        w_rdata[7:0]  = LP_W8;
        w_rdata[15:8] = MAP_VERSION;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_scratch   <= SCRATCH_RST;
      r_shadow_hi <= '0;
    end else begin
      r_rvalid <= w_rd;
      r_rdata  <= w_rd ? w_rdata : '0;
      if (write && (address == REG_SCRATCH)) begin
        r_scratch <= writedata;
      end
      // Snapshot the upper half together with the low-half read so HI pairs with it.
      if (w_rd && (address == REG_UPTIME_LO)) begin
        r_shadow_hi <= w_count[2*DATA_W-1:DATA_W];
      end
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rvalid;
endmodule

// File: tb/tb_nios_system_sysinfo.sv
// tb/tb_nios_system_sysinfo.sv - directed self-checking bench for nios_system_sysinfo (DATA_W 32 and 16)
module tb_nios_system_sysinfo;
  logic        clk;
  logic        rst;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] rdata32;
  logic        rv32;
  logic [15:0] rdata16;
  logic        rv16;

  int n_total;
  int n_bad;

  nios_system_sysinfo dut32 (
    .clock         (clk),
    .reset         (rst),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (rdata32),
    .readdatavalid (rv32)
  );

  nios_system_sysinfo #(
    .DATA_W      (16),
    .ID_VALUE    (32'h1234_5678),
    .SCRATCH_RST (16'hA5A5)
  ) dut16 (
    .clock         (clk),
    .reset         (rst),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata[15:0]),
    .readdata      (rdata16),
    .readdatavalid (rv16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input bit w16, input logic [2:0] a, input logic [31:0] exp, input string tag);
    read = 1'b1;
    write = 1'b0;
    address = a;
    @(posedge clk);
    @(negedge clk);
    read = 1'b0;
    if (w16) begin
      check({tag, "_v"}, {31'b0, rv16}, 32'd1);
      check(tag, {16'b0, rdata16}, exp);
    end else begin
      check({tag, "_v"}, {31'b0, rv32}, 32'd1);
      check(tag, rdata32, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    write = 1'b1;
    read = 1'b0;
    address = a;
    writedata = d;
    @(posedge clk);
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic idle(input string tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_v32"}, {31'b0, rv32}, 32'd0);
    check({tag, "_d32"}, rdata32, 32'd0);
    check({tag, "_v16"}, {31'b0, rv16}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_v32", {31'b0, rv32}, 32'd0);
    check("rst_d32", rdata32, 32'd0);
    check("rst_v16", {31'b0, rv16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    address = 3'd0;
    read = 1'b0;
    write = 1'b0;
    writedata = 32'd0;
    n_total = 0;
    n_bad = 0;
    @(negedge clk);
    do_reset();

    rd(0, 3'd0, 32'd0, "id32");
    idle("pulse1");
    rd(0, 3'd1, 32'd1674984379, "ts32");
    rd(0, 3'd6, 32'h0000_0120, "info32");
    rd(0, 3'd7, 32'd0, "rsvd32");
    rd(0, 3'd5, 32'h0000_0001, "ctrl_rst32");
    idle("pulse2");

    wr(3'd2, 32'hDEAD_BEEF);
    rd(0, 3'd2, 32'hDEAD_BEEF, "scratch32");
    wr(3'd0, 32'h0000_1234);
    rd(0, 3'd0, 32'd0, "id_ro32");
    wr(3'd7, 32'hFFFF_FFFF);
    rd(0, 3'd7, 32'd0, "rsvd_wr32");
    do_reset();
    rd(0, 3'd2, 32'd0, "scratch_rst32");

    // Low-half snapshot must pair with the pre-carry high half.
    force dut32.u_uptime.r_count = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut32.u_uptime.r_count;
    rd(0, 3'd3, 32'hFFFF_FFFF, "up_lo32");
    rd(0, 3'd4, 32'h0000_0000, "up_hi32");

    wr(3'd5, 32'h0000_0000);
    rd(0, 3'd3, 32'h0000_0002, "frozen_a");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
    end
    rd(0, 3'd3, 32'h0000_0002, "frozen_b");
    rd(0, 3'd4, 32'h0000_0001, "frozen_hi");
    rd(0, 3'd5, 32'h0000_0000, "ctrl_off");

    wr(3'd5, 32'h0000_0003);
    rd(0, 3'd3, 32'd0, "clr_lo0");
    rd(0, 3'd3, 32'd1, "clr_lo1");
    for (int i = 0; i < 5; i++) begin
      idle("gap");
    end
    rd(0, 3'd3, 32'd7, "resume");
    rd(0, 3'd5, 32'h0000_0001, "ctrl_on");

    read = 1'b1;
    write = 1'b1;
    address = 3'd2;
    writedata = 32'h1357_2468;
    @(posedge clk);
    @(negedge clk);
    read = 1'b0;
    write = 1'b0;
    check("rdwr_v", {31'b0, rv32}, 32'd0);
    check("rdwr_d", rdata32, 32'd0);
    rd(0, 3'd2, 32'h1357_2468, "rdwr_scr");

    read = 1'b1;
    address = 3'd1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_drop_v", {31'b0, rv32}, 32'd0);
    @(negedge clk);
    read = 1'b0;
    rst = 1'b0;
    idle("post_rst");

    do_reset();
    rd(1, 3'd0, 32'h0000_5678, "id16");
    rd(1, 3'd1, 32'h0000_3BBB, "ts16");
    rd(1, 3'd6, 32'h0000_0110, "info16");
    rd(1, 3'd2, 32'h0000_A5A5, "scratch16");

    force dut16.u_uptime.r_count = 32'hFFFF_FFFF;
    #1;
    release dut16.u_uptime.r_count;
    @(negedge clk);
    rd(1, 3'd3, 32'd0, "wrap_lo16");
    rd(1, 3'd4, 32'd0, "wrap_hi16");
    rd(1, 3'd5, 32'h0000_0005, "wrap_ctrl16");

    force dut16.u_uptime.r_count = 32'hFFFF_FFFF;
    #1;
    release dut16.u_uptime.r_count;
    wr(3'd5, 32'h0000_0003);
    rd(1, 3'd3, 32'd0, "clrwrap_lo16");
    rd(1, 3'd5, 32'h0000_0001, "clrwrap_ctrl16");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
